move_sequencer: RTL

Upstream front-end for the tic-tac-toe game core. Accepts one requested cell index at a time from the host link over a valid/ready handshake, and legality-checks it against the core's board and game-over state. Issues legal moves to the core as a single-cycle move strobe with the correct alternating player, then returns a per-request status response once the core's win/draw result has settled. Also generates the core's clear pulse for a new game and tracks move count.

---
 rtl/move_sequencer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/move_sequencer.sv
// move_sequencer: host-side front end of the tic-tac-toe core.
// Takes one cell request at a time and checks that it is legal.
// Issues legal moves to the core and reports a status once the core result has settled.
module move_sequencer #(
  parameter int unsigned FIRST_PLAYER = 0,
  parameter int unsigned CLEAR_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [3:0]  req_position,
  output logic        req_ready,
  input  logic        new_game,
  input  logic [17:0] board,
  input  logic        core_game_over,
  input  logic [1:0]  core_winner,
  output logic        move_valid,
  output logic        player,
  output logic [3:0]  position,
  output logic        game_clear,
  output logic        resp_valid,
  output logic [1:0]  resp_code,
  output logic [1:0]  resp_winner,
  output logic        resp_game_over,
  output logic [3:0]  move_count
);

  localparam int unsigned CNT_W = (CLEAR_CYCLES < 2) ? 1 : $clog2(CLEAR_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLEAR_CYCLES);
  localparam logic             FIRST_P  = 1'(FIRST_PLAYER);
  localparam logic [3:0]       MAX_POS  = 4'd8;
  localparam logic [3:0]       MAX_MOVES = 4'd9;

  localparam logic [1:0] CODE_OK    = 2'b00;
  localparam logic [1:0] CODE_OCC   = 2'b01;
  localparam logic [1:0] CODE_RANGE = 2'b10;
  localparam logic [1:0] CODE_OVER  = 2'b11;

  typedef enum logic [2:0] {
    IDLE, CHECK, ISSUE, SETTLE1, SETTLE2, RESP, CLEAR
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       req_pos_q, req_pos_d;
  logic             cur_player_q, cur_player_d;
  logic [1:0]       cell_c;
  logic [1:0]       expect_c;

  logic       req_ready_d, move_valid_d, player_d, game_clear_d;
  logic [3:0] position_d, move_count_d;
  logic       resp_valid_d, resp_game_over_d;
  logic [1:0] resp_code_d, resp_winner_d;

  // Board cell at the captured request position (empty when out of range)
  always_comb begin
    cell_c = 2'b00;
    for (int k = 0; k < 9; k++) begin
      if (req_pos_q == 4'(k)) cell_c = board[2*k +: 2];
    end
    expect_c = cur_player_q ? 2'b10 : 2'b01;
  end

  // Next-state and next-output logic
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    req_pos_d        = req_pos_q;
    cur_player_d     = cur_player_q;
    move_valid_d     = 1'b0;
    resp_valid_d     = 1'b0;
    player_d         = player;
    position_d       = position;
    move_count_d     = move_count;
    resp_code_d      = resp_code;
    resp_winner_d    = resp_winner;
    resp_game_over_d = resp_game_over;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_pos_d = req_position;
          state_d   = CHECK;
        end
      end
      CHECK: begin
        if (core_game_over || (req_pos_q > MAX_POS) || (cell_c != 2'b00)) begin
          state_d          = RESP;
          resp_valid_d     = 1'b1;
          resp_winner_d    = core_winner;
          resp_game_over_d = core_game_over;
          if (core_game_over)           resp_code_d = CODE_OVER;
          else if (req_pos_q > MAX_POS) resp_code_d = CODE_RANGE;
          else                          resp_code_d = CODE_OCC;
        end else begin
          state_d      = ISSUE;
          move_valid_d = 1'b1;
          position_d   = req_pos_q;
          player_d     = cur_player_q;
        end
      end
      ISSUE:   state_d = SETTLE1;
      SETTLE1: state_d = SETTLE2;
      SETTLE2: begin
        state_d          = RESP;
        resp_valid_d     = 1'b1;
        resp_winner_d    = core_winner;
        resp_game_over_d = core_game_over;
        if (cell_c == expect_c) begin
          resp_code_d  = CODE_OK;
          cur_player_d = ~cur_player_q;
          move_count_d = (move_count == MAX_MOVES) ? MAX_MOVES : move_count + 4'd1;
        end else begin
          resp_code_d  = CODE_OCC;
        end
      end
      RESP:    state_d = IDLE;
      CLEAR: begin
        if (cnt_q <= CNT_W'(1)) state_d = IDLE;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase

    // New game wins over everything, including a same-cycle handshake
    if (new_game) begin
      state_d          = CLEAR;
      cnt_d            = CNT_LOAD;
      cur_player_d     = FIRST_P;
      player_d         = FIRST_P;
      move_count_d     = 4'd0;
      move_valid_d     = 1'b0;
      resp_valid_d     = 1'b0;
      position_d       = position;
      resp_code_d      = resp_code;
      resp_winner_d    = resp_winner;
      resp_game_over_d = resp_game_over;
    end

    req_ready_d  = (state_d == IDLE);
    game_clear_d = (state_d == CLEAR);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= CLEAR;
      cnt_q          <= CNT_LOAD;
      req_pos_q      <= 4'd0;
      cur_player_q   <= FIRST_P;
      req_ready      <= 1'b0;
      move_valid     <= 1'b0;
      player         <= FIRST_P;
      position       <= 4'd0;
      game_clear     <= 1'b1;
      resp_valid     <= 1'b0;
      resp_code      <= 2'b00;
      resp_winner    <= 2'b00;
      resp_game_over <= 1'b0;
      move_count     <= 4'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      req_pos_q      <= req_pos_d;
      cur_player_q   <= cur_player_d;
      req_ready      <= req_ready_d;
      move_valid     <= move_valid_d;
      player         <= player_d;
      position       <= position_d;
      game_clear     <= game_clear_d;
      resp_valid     <= resp_valid_d;
      resp_code      <= resp_code_d;
      resp_winner    <= resp_winner_d;
      resp_game_over <= resp_game_over_d;
      move_count     <= move_count_d;
    end
  end

endmodule
